// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store unit:
//   - DATA_W      : data word width (32)
//   - OP_*        : access size/sign encodings carried on req_op
//   - ST_*        : FSM state encoding (IDLE/RD/WR/RSP)
//   - req_t       : request fields captured at acceptance
//   - helpers     : op legality, access size, alignment checks
// ----------------------------------------------------------------------------
package mem_access_pkg;

  localparam int DATA_W = 32;

  // Access size/sign encodings. Stores may only use B/H/W.
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  // Request fields held for the duration of one access.
  typedef struct packed {
    logic              we;
    logic [2:0]        op;
    logic [1:0]        off;    // byte offset within the word, already aligned
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic op_is_legal(input logic [2:0] op, input logic we);
    logic legal;
    case (op)
      OP_B, OP_H, OP_W: legal = 1'b1;
      OP_BU, OP_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic op_is_half(input logic [2:0] op);
    return (op == OP_H) || (op == OP_HU);
  endfunction

  function automatic logic op_is_word(input logic [2:0] op);
    return op == OP_W;
  endfunction

  // True when the byte offset does not suit the access size.
  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    return (op_is_half(op) && off[0]) || (op_is_word(op) && (off != 2'b00));
  endfunction

  // Forces the offset onto the natural boundary of the access size.
  function automatic logic [1:0] align_offset(input logic [2:0] op, input logic [1:0] off);
    logic [1:0] res;
    if (op_is_word(op))      res = 2'b00;
    else if (op_is_half(op)) res = {off[1], 1'b0};
    else                     res = off;
    return res;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align  (purely combinational)
// Little-endian lane handling for the load/store unit.
//   i_op         : access op (OP_*)
//   i_off        : aligned byte offset within the word
//   i_word       : word read from memory
//   i_wdata      : store data, relevant lanes in the low bits
//   o_load_data  : selected lane(s), sign- or zero-extended to 32 bits
//   o_store_word : i_word with the target lane(s) replaced by store data
// ----------------------------------------------------------------------------
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_store_word
);

  logic [4:0]        w_byte_lsb;
  logic [4:0]        w_half_lsb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_ins;

  assign w_byte_lsb = {i_off, 3'b000};
  assign w_half_lsb = {i_off[1], 4'b0000};
  assign w_byte     = i_word[w_byte_lsb +: 8];
  assign w_half     = i_word[w_half_lsb +: 16];

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_load_data = i_word;
    case (i_op)
      OP_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_BU:   o_load_data = {24'd0, w_byte};
      OP_H:    o_load_data = {{16{w_half[15]}}, w_half};
      OP_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Store data is replicated across all lanes; the mask picks the target.
  always_comb begin
    w_mask = '1;
    w_ins  = i_wdata;
    case (i_op)
      OP_B: begin
        w_mask = 32'h0000_00FF << w_byte_lsb;
        w_ins  = {4{i_wdata[7:0]}};
      end
      OP_H: begin
        w_mask = 32'h0000_FFFF << w_half_lsb;
        w_ins  = {2{i_wdata[15:0]}};
      end
      default: begin
        w_mask = '1;
        w_ins  = i_wdata;
      end
    endcase
  end

  assign o_store_word = (i_word & ~w_mask) | (w_ins & w_mask);

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between the EX stage and a word-addressed data memory.
// Byte/halfword/word loads are extended; sub-word stores use read-modify-write.
// One response is returned per accepted request.
//
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned
// halfword/word accesses with rsp_err. Without it, the offset is forced onto
// the natural boundary and the access proceeds.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_we, req_op         store flag, access op (OP_*)
//   req_addr, req_wdata    byte address, store data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     extended load data (0 for stores/errors), error flag
//   mem_rd, mem_wr         one-cycle memory strobes
//   mem_addr, mem_wdata    word index, word to write
//   mem_rdata              combinational read data from the memory
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mem_access_pkg::*;

  logic [1:0]        r_state;
  req_t              r_req;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_range_err;
  logic              w_op_err;
  logic              w_align_err;
  logic              w_err;
  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_store_word;

  // Request checks, evaluated on the incoming request in IDLE.
  assign w_range_err = |req_addr[31:ADDR_W+2];
  assign w_op_err    = !op_is_legal(req_op, req_we);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign w_align_err = op_misaligned(req_op, req_addr[1:0]);
  assign w_off       = req_addr[1:0];
`else
  assign w_align_err = 1'b0;
  assign w_off       = align_offset(req_op, req_addr[1:0]);
`endif

  assign w_err = w_range_err || w_op_err || w_align_err;

  mem_lane_align u_lane_align (
    .i_op         (r_req.op),
    .i_off        (r_req.off),
    .i_word       (mem_rdata),
    .i_wdata      (r_req.wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req      <= '{we: req_we, op: req_op, off: w_off, wdata: req_wdata};
            r_mem_addr <= req_addr[ADDR_W+1:2];
            if (w_err) begin
              r_state     <= ST_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (req_we && op_is_word(req_op)) begin
              // Full-word store needs no read.
              r_state     <= ST_WR;
              r_mem_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both read the word first.
              r_state <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (r_req.we) begin
            r_state     <= ST_WR;
            r_mem_wdata <= w_store_word;
          end else begin
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load_data;
          end
        end

        ST_WR: begin
          r_state     <= ST_RSP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end

        ST_RSP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset drops mem_wr in the same instant rather than at the next edge.
  assign mem_rd    = (r_state == ST_RD);
  assign mem_wr    = (r_state == ST_WR);
  assign req_ready = (r_state == ST_IDLE);

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Drives mem_access_unit against a behavioural memory and a byte-level
// reference model; directed cases followed by randomized requests.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

  import mem_access_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int n_checks;
  int n_pass;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: derives the response from the access rules with byte arrays.
  task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit err, output logic [31:0] rdata,
                       output int lat, output int n_rd, output int n_wr,
                       output logic [31:0] new_word, output int idx);
    int size, off;
    bit legal, sgn;
    logic [7:0] bytes [4];
    logic [31:0] word;
    case (op)
      OP_B, OP_BU: size = 1;
      OP_H, OP_HU: size = 2;
      default:     size = 4;
    endcase
    legal = we ? (op == OP_B || op == OP_H || op == OP_W)
               : (op == OP_B || op == OP_H || op == OP_W || op == OP_BU || op == OP_HU);
    sgn  = (op == OP_B) || (op == OP_H);
    off  = int'(addr % 4);
    err  = !legal || (addr >= 32'(4 * DEPTH)) || (ALIGN_EN && (off % size) != 0);
    if (!ALIGN_EN) off = off - (off % size);
    idx  = int'((addr / 4) % DEPTH);
    word = ref_mem[idx];
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    rdata    = 32'd0;
    new_word = word;
    n_rd     = 0;
    n_wr     = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat  = 2;
      n_rd = 1;
      for (int b = 0; b < size; b++) rdata[8*b +: 8] = bytes[off + b];
      if (sgn && rdata[8*size-1])
        for (int b = size; b < 4; b++) rdata[8*b +: 8] = 8'hFF;
    end else begin
      n_wr = 1;
      n_rd = (size == 4) ? 0 : 1;
      lat  = (size == 4) ? 2 : 3;
      for (int b = 0; b < size; b++) bytes[off + b] = wdata[8*b +: 8];
      for (int i = 0; i < 4; i++) new_word[8*i +: 8] = bytes[i];
    end
  endtask

  // One full request/response; hold = cycles rsp_ready stays low in RSP.
  task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, output logic [31:0] obs);
    bit err;
    logic [31:0] exp_rdata, new_word;
    int exp_lat, exp_rd, exp_wr, idx, lat, rd_cnt, wr_cnt;
    model(we, op, addr, wdata, err, exp_rdata, exp_lat, exp_rd, exp_wr, new_word, idx);
    obs = 32'hX;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    lat = 0; rd_cnt = 0; wr_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (mem_rd) begin
        rd_cnt++;
        check("rd_addr", 32'(mem_addr), 32'(idx));
      end
      if (mem_wr) begin
        wr_cnt++;
        check("wr_addr", 32'(mem_addr), 32'(idx));
        check("wr_data", mem_wdata, new_word);
      end
    end
    if (lat == 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rd_count", 32'(rd_cnt), 32'(exp_rd));
    check("wr_count", 32'(wr_cnt), 32'(exp_wr));
    check("rsp_err", {31'd0, rsp_err}, {31'd0, err});
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_no_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
    obs = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_err", {31'd0, rsp_err}, {31'd0, err});
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_busy", {29'd0, req_ready, mem_rd, mem_wr}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    check("ready_again", {31'd0, req_ready}, 32'd1);
    if (we && !err) ref_mem[idx] = new_word;
  endtask

  logic [31:0] obs;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp", {29'd0, rsp_valid, rsp_err, mem_rd}, 32'd0);
    check("rst_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-word store, then sub-word loads of the same word.
    run_req(1'b1, OP_W, 32'h8, 32'hDEADBEEF, 0, obs);
    check("sw_mem2", mem[2], 32'hDEADBEEF);
    run_req(1'b0, OP_B,  32'hB, 32'd0, 0, obs); check("lb_0xB",  obs, 32'hFFFFFFDE);
    run_req(1'b0, OP_BU, 32'hB, 32'd0, 0, obs); check("lbu_0xB", obs, 32'h000000DE);
    run_req(1'b0, OP_H,  32'h8, 32'd0, 0, obs); check("lh_0x8",  obs, 32'hFFFFBEEF);
    run_req(1'b0, OP_HU, 32'hA, 32'd0, 0, obs); check("lhu_0xA", obs, 32'h0000DEAD);

    // Read-modify-write byte store.
    run_req(1'b1, OP_B, 32'h9, 32'h12, 0, obs);
    check("sb_mem2", mem[2], 32'hDEAD12EF);

    // Errors: out of range and illegal op, plus store with unsigned op.
    run_req(1'b0, OP_W,   32'h80, 32'd0, 0, obs);
    run_req(1'b0, 3'b011, 32'h4,  32'd0, 0, obs);
    run_req(1'b1, OP_BU,  32'h4,  32'h55, 0, obs);

    // Misaligned word load; outcome depends on the alignment option.
    run_req(1'b0, OP_W, 32'h6, 32'd0, 0, obs);

    // Response held off for five cycles.
    run_req(1'b0, OP_W, 32'h8, 32'd0, 5, obs);

    // Reset during the write cycle: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = OP_W;
    req_addr  = 32'h10; req_wdata = ~ref_mem[4];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwr_wr_before", {31'd0, mem_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_wr_after", {31'd0, mem_wr}, 32'd0);
    check("rstwr_idle", {31'd0, req_ready}, 32'd1);
    check("rstwr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstwr_still_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("rstwr_mem_kept", mem[4], ref_mem[4]);
    run_req(1'b0, OP_W, 32'h10, 32'd0, 0, obs);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      int          sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = OP_B;
        2, 3:    op = OP_H;
        4, 5:    op = OP_W;
        6:       op = OP_BU;
        7:       op = OP_HU;
        default: op = 3'($urandom_range(0, 7));
      endcase
      addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      run_req(1'($urandom_range(0, 1)), op, addr, $urandom, $urandom_range(0, 2), obs);
    end

    for (int i = 0; i < DEPTH; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the EX-stage result (ALU address, store data) and the word-addressed data memory.
- Converts byte/halfword/word loads and stores into whole-word memory strobes.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Checks address range and alignment, then returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 5, word-index width of the data memory (DEPTH = 2**ADDR_W words; 5 gives 32 words).
- DATA_W, 32, data word width; fixed at 32, present for package consistency.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  access size/sign; encodings in package.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the relevant lanes are the low bits.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; no memory write was performed.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from the memory.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - rsp_valid, rsp_err, mem_rd, mem_wr = 0; rsp_rdata, mem_addr, mem_wdata = 0.
  - A reset mid-operation drops mem_wr immediately. No partial write is retried; the pending response is discarded.
- Byte order is little-endian: lane k = bits 8k+7:8k, selected by addr[1:0]. Halfword uses addr[1] (lanes 0-1 or 2-3).
- Acceptance: when req_valid && req_ready, the unit registers addr, we, op, wdata, and mem_addr = addr[ADDR_W+1:2].
- States:
  - IDLE: accepts a request.
  - RD: mem_rd=1 for exactly 1 cycle; mem_rdata is captured at the end of the cycle.
  - WR: mem_wr=1 for exactly 1 cycle.
  - RSP: holds the response.
- Transitions from IDLE on accept:
  - error → RSP.
  - load → RD.
  - SW → WR.
  - SB/SH → RD.
- Transitions from RD:
  - load → RSP, with rsp_rdata = extended lane(s).
  - SB/SH → WR, with mem_wdata = captured word with the target lane(s) replaced by req_wdata[7:0] or [15:0].
- WR → RSP.
- RSP → IDLE when rsp_ready. rsp_valid and all rsp_* outputs stay stable until then.
- mem_rd and mem_wr are never high in the same cycle and are never high in IDLE or RSP.
- Latency from accept edge to rsp_valid:
  - error: 1 cycle.
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Errors (rsp_err=1, rsp_rdata=0, no memory strobes):
  - illegal op.
  - addr[31:ADDR_W+2] != 0 (out of range; this check is always enabled).
  - misalignment (see optional feature).
- Back-to-back: no new accept until the RSP handshake completes; the earliest next accept is the cycle after rsp_ready.

Optional Feature:
- MEM_ACCESS_ALIGN_CHECK_EN
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0 → rsp_err=1, no memory access.
- Undefined: no alignment error. The address is forced aligned (halfword clears addr[0]; word clears addr[1:0]) and the access proceeds normally.

Decomposition:
- Package mem_access_pkg holds:
  - op constants: OP_B=3'b000, OP_H=3'b001, OP_W=3'b010, OP_BU=3'b100, OP_HU=3'b101. With req_we=1, only B/H/W are legal.
  - state encoding IDLE/RD/WR/RSP.
  - DATA_W.
- One natural sub-module: mem_lane_align (combinational), which does lane extraction/extension for loads and lane merge for stores.

Test Plan:
- After reset, SW addr=0x8, wdata=0xDEADBEEF → mem_wr one cycle with mem_addr=2, mem_wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0.
- Word 2=0xDEADBEEF, LB addr=0xB → rsp_rdata=0xFFFFFFDE; LBU → 0x000000DE; LH addr=0x8 → 0xFFFFBEEF; LHU addr=0xA → 0x0000DEAD.
- Word 2=0xDEADBEEF, SB addr=0x9 wdata=0x12 → RD then WR with mem_wdata=0xDEAD12EF, response 3 cycles after accept.
- LW addr=0x80 with ADDR_W=5 → rsp_err=1, rsp_rdata=0, no mem_rd/mem_wr strobe; also illegal op 3'b011 → rsp_err=1.
- LW addr=0x6:
  - with the macro → rsp_err=1.
  - without → reads word 1.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0. Assert rst_n=0 during the WR cycle → mem_wr falls immediately, state returns to IDLE, no response.
